edge_event_arbiter: RTL

Multi-channel rising-edge event controller. Samples `N_CH` asynchronous-free level inputs, detects a rising edge on each, latches it as a pending event, and serializes pending events to a single consumer through a round-robin arbiter with a valid/ready handshake. It sits between raw status or strobe lines and an interrupt- or event-handling consumer.

---
 rtl/edge_event_arb_pkg.sv | 11 +
 rtl/edge_event_arbiter_if.sv | 13 +
 rtl/edge_det_ch.sv | 58 +++++
 rtl/edge_event_arbiter.sv | 114 +++++++++++
 4 files changed

// File: rtl/edge_event_arb_pkg.sv
// Shared types and limits for the edge event arbiter.
package edge_event_arb_pkg;

  localparam int N_CH_MAX = 32;

  typedef enum logic {
    IDLE  = 1'b0,
    OFFER = 1'b1
  } arb_state_e;

endpackage

// File: rtl/edge_event_arbiter_if.sv
// Event handshake bundle: producer (master) offers a channel id, consumer (slave) accepts.
interface edge_event_arbiter_if #(
  parameter int N_CH = 4
);
  localparam int IDX_W = $clog2(N_CH);

  logic             evt_valid;
  logic [IDX_W-1:0] evt_id;
  logic             evt_ready;

  modport master (output evt_valid, output evt_id, input evt_ready);
  modport slave  (input evt_valid, input evt_id, output evt_ready);
endinterface

// File: rtl/edge_det_ch.sv
// One channel: two-flop rising-edge detect feeding a pending flag.
// Optional sticky overflow flag under EDGE_EVENT_ARB_OVF_EN.
module edge_det_ch (
  input  logic clk,
  input  logic reset,
  input  logic din,
  input  logic en,
  input  logic clr,
  output logic pending
`ifdef EDGE_EVENT_ARB_OVF_EN
  , input  logic ovf_clr
  , output logic ovf
`endif
);

  logic d1_q, d1_d, d2_q, d2_d;
  logic pend_q, pend_d;
  logic set;
`ifdef EDGE_EVENT_ARB_OVF_EN
  logic ovf_q, ovf_d;
`endif

  // Edge detect and flag update; a new edge beats a same-cycle clear.
  always_comb begin
    d1_d   = din;
    d2_d   = d1_q;
    set    = d1_q & ~d2_q & en;
    pend_d = set | (pend_q & ~clr);
`ifdef EDGE_EVENT_ARB_OVF_EN
    ovf_d  = (set & pend_q & ~clr) | (ovf_q & ~ovf_clr);
`endif
  end

  // Channel state registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      d1_q   <= 1'b0;
      d2_q   <= 1'b0;
      pend_q <= 1'b0;
`ifdef EDGE_EVENT_ARB_OVF_EN
      ovf_q  <= 1'b0;
`endif
    end else begin
      d1_q   <= d1_d;
      d2_q   <= d2_d;
      pend_q <= pend_d;
`ifdef EDGE_EVENT_ARB_OVF_EN
      ovf_q  <= ovf_d;
`endif
    end
  end

  assign pending = pend_q;
`ifdef EDGE_EVENT_ARB_OVF_EN
  assign ovf = ovf_q;
`endif

endmodule

// File: rtl/edge_event_arbiter.sv
// Multi-channel rising-edge event controller with round-robin serialization.
// Optional overflow tracking is enabled by defining EDGE_EVENT_ARB_OVF_EN.
module edge_event_arbiter
  import edge_event_arb_pkg::*;
#(
  parameter int N_CH = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [N_CH-1:0]       din,
  input  logic [N_CH-1:0]       mask,
  edge_event_arbiter_if.master  evt,
  output logic [N_CH-1:0]       pending
`ifdef EDGE_EVENT_ARB_OVF_EN
  , output logic [N_CH-1:0]     ovf
  , input  logic [N_CH-1:0]     ovf_clr
`endif
);

  localparam int IDX_W = $clog2(N_CH);

  arb_state_e       state_q, state_d;
  logic [IDX_W-1:0] evt_id_q, evt_id_d;
  logic [IDX_W-1:0] last_q, last_d;
  logic [N_CH-1:0]  elig, clr_vec, excl;
  logic [IDX_W:0]   pick;
  logic             hs;

  // First requester strictly after 'after', wrapping; MSB flags a hit.
  function automatic logic [IDX_W:0] rr_pick(input logic [N_CH-1:0] req,
                                             input logic [IDX_W-1:0] after);
    logic [IDX_W:0] r;
    int j;
    r = '0;
    // Descending scan so the closest candidate is the last one written.
    for (int k = N_CH; k >= 1; k--) begin
      j = (int'(after) + k) % N_CH;
      if (req[j]) r = {1'b1, IDX_W'(j)};
    end
    return r;
  endfunction

  for (genvar i = 0; i < N_CH; i++) begin : g_ch
    edge_det_ch u_ch (
      .clk     (clk),
      .reset   (reset),
      .din     (din[i]),
      .en      (mask[i]),
      .clr     (clr_vec[i]),
      .pending (pending[i])
`ifdef EDGE_EVENT_ARB_OVF_EN
      , .ovf_clr (ovf_clr[i])
      , .ovf     (ovf[i])
`endif
    );
  end

  // Handshake decode: clear vector and accepted-channel exclusion mask.
  always_comb begin
    hs      = (state_q == OFFER) & evt.evt_ready;
    clr_vec = '0;
    excl    = '1;
    for (int i = 0; i < N_CH; i++) begin
      if (evt_id_q == IDX_W'(i)) begin
        clr_vec[i] = hs;
        excl[i]    = 1'b0;
      end
    end
    elig = pending & mask;
  end

  // Offer FSM: hold the id until accepted, then chain to the next winner.
  always_comb begin
    state_d  = state_q;
    evt_id_d = evt_id_q;
    last_d   = last_q;
    pick     = '0;
    unique case (state_q)
      IDLE: begin
        pick = rr_pick(elig, last_q);
        if (pick[IDX_W]) begin
          state_d  = OFFER;
          evt_id_d = pick[IDX_W-1:0];
        end
      end
      OFFER: begin
        if (hs) begin
          last_d = evt_id_q;
          pick   = rr_pick(elig & excl, evt_id_q);
          if (pick[IDX_W]) evt_id_d = pick[IDX_W-1:0];
          else             state_d  = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Arbiter registers; last starts at N_CH-1 so channel 0 leads.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= IDLE;
      evt_id_q <= '0;
      last_q   <= IDX_W'(N_CH - 1);
    end else begin
      state_q  <= state_d;
      evt_id_q <= evt_id_d;
      last_q   <= last_d;
    end
  end

  assign evt.evt_valid = (state_q == OFFER);
  assign evt.evt_id    = evt_id_q;

endmodule
